// File: rtl/btn_pkg.sv
// Shared types and default constants for the speed-button conditioning path.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM_HI  = 2'd1,
        PRESSED = 2'd2,
        ARM_LO  = 2'd3
    } btn_state_e;

    localparam int unsigned SYNC_STAGES_DEF  = 2;
    localparam int unsigned DEBOUNCE_CYC_DEF = 20000;
    localparam int unsigned LONG_CYC_DEF     = 1000000;
    localparam int unsigned CNT_W_DEF        = 20;

endpackage

// File: rtl/btn_sync.sv
// Multi-stage flop synchronizer for the raw asynchronous button input.
module btn_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Debounces the speed button into level, press, release and (with BTN_LONGPRESS_EN) long-hold events.
module button_debounce
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned LONG_CYC     = LONG_CYC_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || LONG_CYC < 2 ||
        (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYC) || (64'd1 << CNT_W) <= 64'(LONG_CYC)) begin : g_param_err
        $error("button_debounce: illegal parameter combination");
    end

    logic s;

    btn_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_in),
        .q_o   (s)
    );

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

`ifdef BTN_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYC - 2);

    // Hold counter is separate from the debounce counter so a bounce through ARM_LO only pauses it.
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             long_q, long_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BTN_LONGPRESS_EN
            hold_q    <= '0;
            long_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef BTN_LONGPRESS_EN
            hold_q    <= hold_d;
            long_q    <= long_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_LONGPRESS_EN
        hold_d    = hold_q;
        long_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = ARM_HI;
                    cnt_d   = '0;
                end
            end
            ARM_HI: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
`ifdef BTN_LONGPRESS_EN
                    hold_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = ARM_LO;
                    cnt_d   = '0;
                end
`ifdef BTN_LONGPRESS_EN
                else if (hold_q != LONG_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                    long_d = (hold_q == LONG_PRE);
                end
`endif
            end
            ARM_LO: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == ARM_LO);
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`ifdef BTN_LONGPRESS_EN
    assign long_pulse    = long_q;
`else
    assign long_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: vector table plus multi-cycle corner sequences.
module tb_button_debounce;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DB   = 4;
    localparam int unsigned LONG = 16;
    localparam int unsigned CW   = 8;
    localparam int LAT = SYNC + DB;
`ifdef BTN_LONGPRESS_EN
    localparam int EXP_LONG_N = 1;
`else
    localparam int EXP_LONG_N = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_pulse;

    always #5 clk = ~clk;

    button_debounce #(
        .SYNC_STAGES  (SYNC),
        .DEBOUNCE_CYC (DB),
        .LONG_CYC     (LONG),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    typedef struct packed {
        logic rst;
        logic btn;
        logic level;
        logic press;
        logic rel;
        logic lng;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic b);
        reset  = r;
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    // Holds btn at b for n edges; reports pulse counts, first pulse index and cycles with level low.
    task automatic run(input logic b, input int n,
                       output int np, output int ip, output int nr, output int ir,
                       output int nl, output int il, output int nlow);
        np = 0; ip = -1; nr = 0; ir = -1; nl = 0; il = -1; nlow = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b0, b);
            if (press_pulse)   begin np++; if (ip < 0) ip = i; end
            if (release_pulse) begin nr++; if (ir < 0) ir = i; end
            if (long_pulse)    begin nl++; if (il < 0) il = i; end
            if (!btn_level)    nlow++;
            if (press_pulse && release_pulse) chk("press_and_release_same_cycle", 1, 0);
        end
    endtask

    initial begin
        int np, ip, nr, ir, nl, il, nlow;

        // Reset held with button down, clean press, clean release.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < LAT; i++) vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < LAT; i++) vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        for (int v = 0; v < vecs.size(); v++) begin
            tick(vecs[v].rst, vecs[v].btn);
            chk($sformatf("vec%0d level", v),   int'(btn_level),     int'(vecs[v].level));
            chk($sformatf("vec%0d press", v),   int'(press_pulse),   int'(vecs[v].press));
            chk($sformatf("vec%0d release", v), int'(release_pulse), int'(vecs[v].rel));
            chk($sformatf("vec%0d long", v),    int'(long_pulse),    int'(vecs[v].lng));
        end

        // Long hold: one press, long pulse only when compiled in, then a clean release.
        run(1'b1, 40, np, ip, nr, ir, nl, il, nlow);
        chk("long_press_cnt", np, 1);
        chk("long_press_idx", ip, LAT);
        chk("long_pulse_cnt", nl, EXP_LONG_N);
`ifdef BTN_LONGPRESS_EN
        chk("long_pulse_idx", il, LAT + int'(LONG) - 1);
`endif
        run(1'b0, 8, np, ip, nr, ir, nl, il, nlow);
        chk("long_rel_cnt", nr, 1);
        chk("long_rel_idx", ir, LAT);

        // Bounce 1,1,1,0 x5 then steady: single press 6 edges into the steady high.
        for (int k = 0; k < 5; k++) begin
            run(1'b1, 3, np, ip, nr, ir, nl, il, nlow);
            chk($sformatf("bounce%0d_hi_press", k), np, 0);
            run(1'b0, 1, np, ip, nr, ir, nl, il, nlow);
            chk($sformatf("bounce%0d_lo_press", k), np, 0);
        end
        run(1'b1, 12, np, ip, nr, ir, nl, il, nlow);
        chk("bounce_press_cnt", np, 1);
        chk("bounce_press_idx", ip, LAT);

        // One-cycle low glitch while pressed: no release, level stays high.
        run(1'b0, 1, np, ip, nr, ir, nl, il, nlow);
        chk("glitch_rel_a", nr, 0);
        chk("glitch_low_a", nlow, 0);
        run(1'b1, 12, np, ip, nr, ir, nl, il, nlow);
        chk("glitch_rel_b", nr, 0);
        chk("glitch_press_b", np, 0);
        chk("glitch_low_b", nlow, 0);
        run(1'b0, 8, np, ip, nr, ir, nl, il, nlow);
        chk("glitch_final_rel_cnt", nr, 1);
        chk("glitch_final_rel_idx", ir, LAT);

        // Reset two cycles into ARM_HI aborts the press.
        run(1'b1, 4, np, ip, nr, ir, nl, il, nlow);
        chk("abort_pre_press", np, 0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1);
            chk($sformatf("abort_rst%0d_press", i), int'(press_pulse), 0);
            chk($sformatf("abort_rst%0d_level", i), int'(btn_level), 0);
        end
        run(1'b0, 8, np, ip, nr, ir, nl, il, nlow);
        chk("abort_post_press", np, 0);
        chk("abort_post_rel", nr, 0);
        chk("abort_post_low", nlow, 8);
        run(1'b1, 10, np, ip, nr, ir, nl, il, nlow);
        chk("fresh_press_cnt", np, 1);
        chk("fresh_press_idx", ip, LAT);
        chk("fresh_level", int'(btn_level), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
